// File: rtl/led_matrix_scan_if.sv
// Brightness write bus for led_matrix_scan: valid/ready handshake
// carrying a row/column address and a 4-bit brightness value.
`timescale 1ns/1ps
interface led_matrix_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_row;
  logic [3:0] wr_col;
  logic [3:0] wr_data;

  modport master (
    output wr_valid, wr_row, wr_col, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/led_matrix_scan.sv
// 3x11 LED matrix row scanner with 4-bit PWM per LED.
// Define LED_SCAN_BLANK_EN to insert BLANK_TICKS of dark time between rows.
`timescale 1ns/1ps
module led_matrix_scan #(
  parameter int unsigned CLK_DIV     = 64,
  parameter int unsigned BLANK_TICKS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  led_matrix_scan_if.slave  wr,
  output logic [2:0]        leda,
  output logic [10:0]       ledc,
  output logic              frame_start
);

  if (CLK_DIV < 2 || CLK_DIV > 65535 ||
      BLANK_TICKS < 1 || BLANK_TICKS > 15) begin : g_bad_param
    $error("led_matrix_scan: parameter out of range");
  end

`ifdef LED_SCAN_BLANK_EN
  typedef enum logic [0:0] {SCAN, BLANK} state_e;
`else
  typedef enum logic [0:0] {SCAN} state_e;
`endif

  state_e                  state_q, state_d;
  logic [15:0]             presc_q, presc_d;
  logic [3:0]              phase_q, phase_d;
  logic [1:0]              row_q, row_d;
  logic                    fpend_q, fpend_d;
  logic [2:0]              leda_q, leda_d;
  logic [10:0]             ledc_q, ledc_d;
  logic                    fs_q, fs_d;
  logic [2:0][10:0][3:0]   bright_q;
`ifdef LED_SCAN_BLANK_EN
  logic [3:0]              bcnt_q, bcnt_d;
`endif

  // Accepted writes are staged one cycle before landing in the store
  logic       wp_q;
  logic [1:0] wp_row_q;
  logic [3:0] wp_col_q;
  logic [3:0] wp_data_q;

  logic       wr_acc;
  logic       tick;
  logic [1:0] row_nxt;

  assign wr.wr_ready = reset;
  assign wr_acc  = wr.wr_valid && wr.wr_ready &&
                   (wr.wr_row != 2'd3) && (wr.wr_col <= 4'd10);
  assign tick    = en && (presc_q == 16'(CLK_DIV - 1));
  assign row_nxt = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;

  assign leda        = leda_q;
  assign ledc        = ledc_q;
  assign frame_start = fs_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SCAN;
      presc_q   <= '0;
      phase_q   <= '0;
      row_q     <= '0;
      fpend_q   <= 1'b0;
      leda_q    <= '0;
      ledc_q    <= '0;
      fs_q      <= 1'b0;
      bright_q  <= '0;
      wp_q      <= 1'b0;
      wp_row_q  <= '0;
      wp_col_q  <= '0;
      wp_data_q <= '0;
`ifdef LED_SCAN_BLANK_EN
      bcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      row_q     <= row_d;
      fpend_q   <= fpend_d;
      leda_q    <= leda_d;
      ledc_q    <= ledc_d;
      fs_q      <= fs_d;
      wp_q      <= wr_acc;
      wp_row_q  <= wr.wr_row;
      wp_col_q  <= wr.wr_col;
      wp_data_q <= wr.wr_data;
`ifdef LED_SCAN_BLANK_EN
      bcnt_q    <= bcnt_d;
`endif
      if (wp_q) begin
        bright_q[wp_row_q][wp_col_q] <= wp_data_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    row_d   = row_q;
    fpend_d = fpend_q;
    leda_d  = '0;
    ledc_d  = '0;
    fs_d    = 1'b0;
`ifdef LED_SCAN_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    if (en) begin
      presc_d = tick ? '0 : presc_q + 16'd1;
      if (state_q == SCAN) begin
        leda_d = 3'b001 << row_q;
        for (int c = 0; c < 11; c++) begin
          ledc_d[c] = bright_q[row_q][c] > phase_q;
        end
        if (row_q == 2'd0 && fpend_q) begin
          fs_d    = 1'b1;
          fpend_d = 1'b0;
        end
      end
      if (tick) begin
        if (state_q == SCAN) begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
`ifdef LED_SCAN_BLANK_EN
            state_d = BLANK;
            bcnt_d  = '0;
`else
            row_d = row_nxt;
            if (row_q == 2'd2) fpend_d = 1'b1;
`endif
          end
        end
`ifdef LED_SCAN_BLANK_EN
        else begin
          if (bcnt_q == 4'(BLANK_TICKS - 1)) begin
            state_d = SCAN;
            phase_d = '0;
            row_d   = row_nxt;
            if (row_q == 2'd2) fpend_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed self-checking bench for led_matrix_scan, CLK_DIV=4.
// Row period and blank count follow LED_SCAN_BLANK_EN.
`timescale 1ns/1ps
module tb_led_matrix_scan;
`ifdef LED_SCAN_BLANK_EN
  localparam int RP = 72;
  localparam int NZ = 24;
`else
  localparam int RP = 64;
  localparam int NZ = 0;
`endif
  localparam int FRAME = 3 * RP;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  leda;
  logic [10:0] ledc;
  logic        frame_start;

  led_matrix_scan_if bus ();

  led_matrix_scan #(
    .CLK_DIV     (4),
    .BLANK_TICKS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .wr          (bus),
    .leda        (leda),
    .ledc        (ledc),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(logic [1:0] r, logic [3:0] c, logic [3:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_row   = r;
    bus.wr_col   = c;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  int r0_on, r0_dk, r1_on, r1_dk, r2_on, r2_dk;
  int nzero, nother, nfs, bad, n;
  logic [2:0] first_leda;

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_row   = '0;
    bus.wr_col   = '0;
    bus.wr_data  = '0;

    // reset held, enabled, write attempted
    en = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_row   = 2'd0;
    bus.wr_col   = 4'd0;
    bus.wr_data  = 4'd15;
    repeat (3) step();
    check("rst_leda", leda, 0);
    check("rst_ledc", ledc, 0);
    check("rst_fs", frame_start, 0);
    check("rst_ready", bus.wr_ready, 0);
    bus.wr_valid = 1'b0;
    en = 1'b0;
    reset = 1'b1;
    #1;
    check("ready_up", bus.wr_ready, 1);
    step();
    check("dis_leda", leda, 0);

    write(2'd0, 4'd5, 4'd15);
    write(2'd1, 4'd0, 4'd8);
    write(2'd3, 4'd0, 4'd15);
    write(2'd0, 4'd11, 4'd15);
    write(2'd2, 4'd10, 4'd15);
    repeat (2) step();

    // one full frame of scan from the reset position
    en = 1'b1;
    r0_on = 0; r0_dk = 0; r1_on = 0; r1_dk = 0;
    r2_on = 0; r2_dk = 0; nzero = 0; nother = 0; nfs = 0;
    first_leda = '0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i == 0) first_leda = leda;
      if (frame_start) nfs++;
      if (leda == 3'b001 && ledc == 11'h020) r0_on++;
      else if (leda == 3'b001 && ledc == 11'h000) r0_dk++;
      else if (leda == 3'b010 && ledc == 11'h001) r1_on++;
      else if (leda == 3'b010 && ledc == 11'h000) r1_dk++;
      else if (leda == 3'b100 && ledc == 11'h400) r2_on++;
      else if (leda == 3'b100 && ledc == 11'h000) r2_dk++;
      else if (leda == 3'b000 && ledc == 11'h000) nzero++;
      else nother++;
    end
    check("first_row0", first_leda, 3'b001);
    check("r0_lit", r0_on, 60);
    check("r0_dark", r0_dk, 4);
    check("r1_lit", r1_on, 32);
    check("r1_dark", r1_dk, 32);
    check("r2_lit", r2_on, 60);
    check("r2_dark", r2_dk, 4);
    check("blank_cyc", nzero, NZ);
    check("bad_pattern", nother, 0);
    check("fs_after_rst", nfs, 0);

    step();
    check("fs_pulse", frame_start, 1);
    check("fs_leda", leda, 3'b001);
    step();
    check("fs_width", frame_start, 0);
    n = 1;
    while (!frame_start && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("fs_period", n, FRAME);

    // stop in row 1, phase 7
    repeat (RP + 29) step();
    check("p7_leda", leda, 3'b010);
    check("p7_ledc", ledc, 11'h001);
    en = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (leda != 0 || ledc != 0 || frame_start != 0) bad++;
    end
    check("pause_dark", bad, 0);
    en = 1'b1;
    step();
    check("res1_leda", leda, 3'b010);
    check("res1_ledc", ledc, 11'h001);
    check("res1_fs", frame_start, 0);
    step();
    check("res2_ledc", ledc, 11'h001);
    step();
    check("res3_ledc", ledc, 11'h000);
    check("res3_leda", leda, 3'b010);

    // reset pulse mid-row
    reset = 1'b0;
    step();
    check("mid_rst_leda", leda, 0);
    check("mid_rst_ledc", ledc, 0);
    check("mid_rst_ready", bus.wr_ready, 0);
    reset = 1'b1;
    step();
    check("rel_leda", leda, 3'b001);
    check("rel_fs", frame_start, 0);
    check("rel_ledc", ledc, 0);
    repeat (2 * RP) step();
    check("row2_leda", leda, 3'b100);
    check("row2_clr", ledc, 0);

    // write latency, row 2 active
    write(2'd2, 4'd3, 4'd15);
    check("lat_n", ledc, 0);
    step();
    check("lat_n1", ledc, 0);
    step();
    check("lat_n2", ledc, 11'h008);
    check("lat_leda", leda, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 Parameter CLK_DIV, default 64: clk cycles per PWM tick, legal range 2..65535.
REQ-002 Parameter BLANK_TICKS, default 2: PWM ticks of inter-row blanking, legal range 1..15; used only when LED_SCAN_BLANK_EN is defined.
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 en  input  1  scan enable; 0 = outputs dark, counters held.
REQ-006 wr_valid  input  1  brightness write request.
REQ-007 wr_ready  output  1  write accept; a write SHALL complete on a cycle with wr_valid=1 and wr_ready=1.
REQ-008 wr_row  input  2  target row, legal 0..2.
REQ-009 wr_col  input  4  target column, legal 0..10.
REQ-010 wr_data  input  4  brightness, 0 = off, 15 = maximum.
REQ-011 leda  output  3  one-hot active-high row drive.
REQ-012 ledc  output  11  active-high column drive; 1 = LED lit.
REQ-013 frame_start  output  1  one-cycle pulse at the start of each row-0 slot.

Function
REQ-014 Brightness store: 33 four-bit registers, indexed [row][col].
REQ-015 wr_ready SHALL be 1 whenever reset=1; writes SHALL be accepted regardless of en.
REQ-016 An accepted write with wr_row=3 or wr_col>10 SHALL be discarded without altering any register.
REQ-017 A write accepted at edge N SHALL be reflected on ledc from edge N+2 when its row is active.
REQ-018 Prescaler counts 0..CLK_DIV-1 and wraps; tick = prescaler at CLK_DIV-1 with en=1.
REQ-019 Phase counter 0..15 SHALL increment on each tick in SCAN and wrap 15->0.
REQ-020 States: SCAN, BLANK; BLANK SHALL exist only when LED_SCAN_BLANK_EN is defined.
REQ-021 SCAN, tick with phase=15: SHALL advance to row (row+1) mod 3, or enter BLANK if blanking is compiled in.
REQ-022 BLANK: SHALL hold for BLANK_TICKS ticks, then advance row and return to SCAN with phase=0.
REQ-023 In SCAN, registered outputs: leda = one-hot(row); ledc[c] = (bright[row][c] > phase).
REQ-024 In BLANK, leda and ledc SHALL be all zeros.
REQ-025 frame_start SHALL pulse for exactly one cycle, coincident with the first cycle leda=3'b001 following a row-2 slot.
REQ-026 en=0: leda=0 and ledc=0 from the next edge; prescaler, phase, row and state held; frame_start=0.
REQ-027 en 0->1: scan SHALL resume from the held position, with no frame_start pulse unless REQ-025 applies.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path except wr_ready.

Reset
REQ-029 reset=0 at an edge: prescaler=0, phase=0, row=0, state=SCAN.
REQ-030 reset=0 at an edge: all 33 brightness registers=0.
REQ-031 reset=0 at an edge: leda=0, ledc=0, frame_start=0, wr_ready=0.
REQ-032 A write presented during reset SHALL be ignored.
REQ-033 Reset asserted mid-row or mid-blank SHALL abort immediately; after release, the first enabled edge SHALL drive leda=3'b001 without a frame_start pulse.

Configuration
REQ-034 Macro LED_SCAN_BLANK_EN defined: BLANK state present; row period = (16+BLANK_TICKS)*CLK_DIV cycles.
REQ-035 Macro LED_SCAN_BLANK_EN undefined: no BLANK state, BLANK_TICKS ignored; row period = 16*CLK_DIV cycles; leda never all-zero while en=1 and reset=1.

Verification
REQ-036 CLK_DIV=4, no blank; write [0][5]=15, all others 0 -> ledc=11'h020 for 60 of every 64 cycles of row 0; rows 1 and 2 dark.
REQ-037 CLK_DIV=4, no blank; [1][0]=8 -> ledc[0]=1 for exactly 32 of the 64 row-1 cycles; frame_start period=192 cycles.
REQ-038 CLK_DIV=4, LED_SCAN_BLANK_EN, BLANK_TICKS=2 -> leda=0 for 8 cycles between rows; frame_start period=216 cycles.
REQ-039 Writes with row=3,col=0 and row=0,col=11, data=15 -> no ledc bit ever set; later legal write [2][10]=15 -> ledc[10] lit in row 2.
REQ-040 en=0 for 100 cycles mid-row-1 at phase 7 -> outputs 0 throughout; on en=1, row 1 resumes at phase 7; reset pulse mid-row -> outputs 0, brightness cleared, scan restarts at row 0.
